// File: rtl/music_score_player.sv
// Writable score RAM plus a tempo-driven playback sequencer with play/pause/stop/loop.
// note_out is the registered RAM word at play_addr, so it trails play_addr by one cycle.
module music_score_player #(
    parameter int ROM_WIDTH   = 12,
    parameter int ADDR_WIDTH  = 7,
    parameter int ROM_DEPTH   = 128,
    parameter int TEMPO_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_play,
    input  logic                   cmd_pause,
    input  logic                   cmd_stop,
    input  logic                   loop_en,
    input  logic [TEMPO_WIDTH-1:0] tempo_div,
    input  logic [ADDR_WIDTH-1:0]  song_len,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [ROM_WIDTH-1:0]   wr_data,
    output logic [ROM_WIDTH-1:0]   note_out,
    output logic [ADDR_WIDTH-1:0]  play_addr,
    output logic                   playing,
    output logic                   paused,
    output logic                   beat_tick,
    output logic                   done
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_PAUSE} state_t;

    localparam logic [TEMPO_WIDTH-1:0] DIV_ONE  = TEMPO_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_ONE = ADDR_WIDTH'(1);

    logic [ROM_WIDTH-1:0]   mem [ROM_DEPTH];

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [TEMPO_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  len_q, len_d;
    logic [ROM_WIDTH-1:0]   note_q, note_d;
    logic                   playing_q, playing_d;
    logic                   paused_q, paused_d;
    logic                   tick_q, tick_d;
    logic                   done_q, done_d;

    logic [TEMPO_WIDTH-1:0] eff_div;
    logic                   beat_end;
    logic                   last_beat;

    // Score storage has no reset so a loaded song survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // >= rather than == so a tempo lowered mid-beat ends the beat immediately.
    assign eff_div   = (tempo_div == '0) ? DIV_ONE : tempo_div;
    assign beat_end  = (cnt_q >= eff_div - DIV_ONE);
    assign last_beat = (addr_q == len_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        note_d  = (state_q == S_PLAY) ? mem[addr_q] : '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_play && !cmd_stop) begin
                    state_d = S_PLAY;
                    addr_d  = '0;
                    cnt_d   = '0;
                    len_d   = song_len;
                end
            end
            S_PLAY: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else begin
                    // The pausing cycle is still a PLAY cycle, so it advances like any other.
                    if (beat_end) begin
                        cnt_d  = '0;
                        tick_d = 1'b1;
                        if (!last_beat) begin
                            addr_d = addr_q + ADDR_ONE;
                        end else begin
                            addr_d = '0;
                            if (!loop_en && !cmd_pause) begin
                                state_d = S_IDLE;
                                tick_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_ONE;
                    end
                    if (cmd_pause) state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (cmd_play) begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                cnt_d   = '0;
            end
        endcase

        playing_d = (state_d == S_PLAY);
        paused_d  = (state_d == S_PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            note_q    <= '0;
            playing_q <= 1'b0;
            paused_q  <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            note_q    <= note_d;
            playing_q <= playing_d;
            paused_q  <= paused_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign note_out  = note_q;
    assign play_addr = addr_q;
    assign playing   = playing_q;
    assign paused    = paused_q;
    assign beat_tick = tick_q;
    assign done      = done_q;

endmodule

// File: tb/tb_music_score_player.sv
// Bench for music_score_player: directed scenarios plus randomized commands checked
// against a model that tracks elapsed PLAY cycles rather than address/counter registers.
module tb_music_score_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_play, cmd_pause, cmd_stop, loop_en;
    logic [23:0] tempo_div;
    logic [6:0]  song_len;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [11:0] wr_data;
    logic [11:0] note_out;
    logic [6:0]  play_addr;
    logic        playing, paused, beat_tick, done;

    int checks = 0;
    int errors = 0;

    music_score_player #(
        .ROM_WIDTH(12), .ADDR_WIDTH(7), .ROM_DEPTH(128), .TEMPO_WIDTH(24)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_play(cmd_play), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
        .loop_en(loop_en), .tempo_div(tempo_div), .song_len(song_len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .note_out(note_out), .play_addr(play_addr), .playing(playing),
        .paused(paused), .beat_tick(beat_tick), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: position in the song is just the number of PLAY cycles elapsed.
    int          m_mode = 0;
    int          m_pc   = 0;
    int          m_len  = 0;
    int          m_div, m_period;
    logic [11:0] m_ram [128];
    logic [11:0] m_note = '0;
    logic        m_tick = 1'b0;
    logic        m_done = 1'b0;

    function automatic int exp_addr();
        int div;
        div = (tempo_div == 0) ? 1 : int'(tempo_div);
        if (m_mode == 0) return 0;
        return (m_pc / div) % (m_len + 1);
    endfunction

    always @(posedge clk) begin
        m_div = (tempo_div == 0) ? 1 : int'(tempo_div);
        if (rst) begin
            m_mode = 0; m_pc = 0; m_len = 0;
            m_note = '0; m_tick = 1'b0; m_done = 1'b0;
        end else begin
            m_note = (m_mode == 1) ? m_ram[exp_addr()] : 12'h000;
            m_tick = 1'b0;
            m_done = 1'b0;
            case (m_mode)
                0: if (cmd_play && !cmd_stop) begin
                    m_mode = 1; m_pc = 0; m_len = int'(song_len);
                end
                1: if (cmd_stop) begin
                    m_mode = 0; m_pc = 0;
                end else begin
                    m_period = m_div * (m_len + 1);
                    m_pc++;
                    if (m_pc % m_div == 0) begin
                        m_tick = 1'b1;
                        if (m_pc == m_period) begin
                            m_pc = 0;
                            if (!loop_en && !cmd_pause) begin
                                m_mode = 0; m_tick = 1'b0; m_done = 1'b1;
                            end
                        end
                    end
                    if (cmd_pause) m_mode = 2;
                end
                2: if (cmd_stop) begin
                    m_mode = 0; m_pc = 0;
                end else if (cmd_play) begin
                    m_mode = 1;
                end
                default: m_mode = 0;
            endcase
        end
        if (wr_en) m_ram[wr_addr] = wr_data;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_play();
        cmd_play = 1'b1; cyc(1); cmd_play = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; cyc(1); cmd_stop = 1'b0;
    endtask

    task automatic write_word(input logic [6:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d; cyc(1); wr_en = 1'b0;
    endtask

    function automatic logic [11:0] rand_word();
        return {1'b0, 3'($urandom), 1'b0, 3'($urandom), 1'b0, 3'($urandom)};
    endfunction

    task automatic load_score();
        for (int i = 0; i < 128; i++) write_word(7'(i), rand_word());
        write_word(7'd0, 12'h001);
        write_word(7'd1, 12'h002);
        write_word(7'd2, 12'h000);
        write_word(7'd3, 12'h005);
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(2);
        checks++;
        if ({note_out, play_addr, playing, paused, beat_tick, done} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected 0",
                     {note_out, play_addr, playing, paused, beat_tick, done});
        end
        rst = 1'b0; cyc(1);
    endtask

    task automatic test_play_once();
        logic [11:0] score [4];
        logic [11:0] exp_n;
        int ticks, dones;
        score = '{12'h001, 12'h002, 12'h000, 12'h005};
        tempo_div = 24'd4; song_len = 7'd3; loop_en = 1'b0;
        pulse_play();
        ticks = 0; dones = 0;
        for (int k = 0; k < 16; k++) begin
            exp_n = (k == 0) ? 12'h000 : score[(k - 1) / 4];
            checks++;
            if (play_addr !== 7'(k / 4) || playing !== 1'b1) begin
                errors++;
                $display("[TB] FAIL once_addr k=%0d: got addr %0d playing %b expected addr %0d playing 1",
                         k, play_addr, playing, k / 4);
            end
            checks++;
            if (note_out !== exp_n) begin
                errors++;
                $display("[TB] FAIL once_note k=%0d: got %h expected %h", k, note_out, exp_n);
            end
            ticks += int'(beat_tick);
            dones += int'(done);
            cyc(1);
        end
        checks++;
        if (ticks != 3 || dones != 0) begin
            errors++;
            $display("[TB] FAIL once_pulses: got ticks %0d dones %0d expected 3 and 0", ticks, dones);
        end
        checks++;
        if ({done, playing, beat_tick, play_addr, note_out} !== {3'b100, 7'd0, 12'h005}) begin
            errors++;
            $display("[TB] FAIL once_done: got done %b playing %b tick %b addr %0d note %h expected 1 0 0 0 005",
                     done, playing, beat_tick, play_addr, note_out);
        end
        cyc(1);
        checks++;
        if (done !== 1'b0 || note_out !== 12'h000 || playing !== 1'b0) begin
            errors++;
            $display("[TB] FAIL once_after: got done %b note %h playing %b expected 0 000 0",
                     done, note_out, playing);
        end
    endtask

    task automatic test_loop();
        tempo_div = 24'd4; song_len = 7'd3; loop_en = 1'b1;
        pulse_play();
        cyc(16);
        checks++;
        if ({play_addr, beat_tick, done, playing, note_out} !== {7'd0, 3'b101, 12'h005}) begin
            errors++;
            $display("[TB] FAIL loop_wrap: got addr %0d tick %b done %b playing %b note %h expected 0 1 0 1 005",
                     play_addr, beat_tick, done, playing, note_out);
        end
        cyc(1);
        checks++;
        if (note_out !== 12'h001) begin
            errors++;
            $display("[TB] FAIL loop_note: got %h expected 001", note_out);
        end
        pulse_stop();
        checks++;
        if (playing !== 1'b0 || play_addr !== 7'd0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loop_stop: got playing %b addr %0d done %b expected 0 0 0",
                     playing, play_addr, done);
        end
        loop_en = 1'b0;
        cyc(1);
    endtask

    task automatic test_pause_resume();
        int count, n;
        tempo_div = 24'd4; song_len = 7'd3; loop_en = 1'b0;
        pulse_play();
        cyc(5);
        cmd_pause = 1'b1; cyc(1); cmd_pause = 1'b0;
        checks++;
        if (paused !== 1'b1 || playing !== 1'b0 || play_addr !== 7'd1) begin
            errors++;
            $display("[TB] FAIL pause_enter: got paused %b playing %b addr %0d expected 1 0 1",
                     paused, playing, play_addr);
        end
        for (int j = 2; j <= 10; j++) begin
            cyc(1);
            checks++;
            if (note_out !== 12'h000 || paused !== 1'b1) begin
                errors++;
                $display("[TB] FAIL pause_hold j=%0d: got note %h paused %b expected 000 1",
                         j, note_out, paused);
            end
        end
        pulse_play();
        checks++;
        if (playing !== 1'b1 || play_addr !== 7'd1) begin
            errors++;
            $display("[TB] FAIL pause_resume: got playing %b addr %0d expected 1 1", playing, play_addr);
        end
        count = 0; n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (playing === 1'b1) count++;
            cyc(1);
            n++;
        end
        checks++;
        if (n >= 40 || count != 10) begin
            errors++;
            $display("[TB] FAIL pause_total: got %0d resumed PLAY cycles (waited %0d) expected 10", count, n);
        end
        cyc(2);
    endtask

    task automatic test_stop_priority();
        int dones;
        tempo_div = 24'd4; song_len = 7'd3; loop_en = 1'b0;
        pulse_play();
        cyc(3);
        cmd_stop = 1'b1; cmd_play = 1'b1; cyc(1);
        cmd_stop = 1'b0; cmd_play = 1'b0;
        checks++;
        if ({playing, paused, done, play_addr} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL stop_prio: got playing %b paused %b done %b addr %0d expected all 0",
                     playing, paused, done, play_addr);
        end
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            dones += int'(done) + int'(playing);
            cyc(1);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("[TB] FAIL stop_quiet: got %0d done/playing cycles expected 0", dones);
        end
    endtask

    task automatic test_reset_mid_song();
        tempo_div = 24'd4; song_len = 7'd3; loop_en = 1'b0;
        pulse_play();
        cyc(6);
        rst = 1'b1; cyc(1);
        checks++;
        if ({note_out, play_addr, playing, paused, beat_tick, done} !== 23'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid: got %h expected 0",
                     {note_out, play_addr, playing, paused, beat_tick, done});
        end
        rst = 1'b0; cyc(1);
        pulse_play();
        cyc(5);
        checks++;
        if (note_out !== 12'h002) begin
            errors++;
            $display("[TB] FAIL reset_ram: got %h expected 002", note_out);
        end
        pulse_stop();
        cyc(1);
    endtask

    task automatic test_min_tempo();
        tempo_div = 24'd0; song_len = 7'd0; loop_en = 1'b0;
        pulse_play();
        checks++;
        if (playing !== 1'b1 || play_addr !== 7'd0 || note_out !== 12'h000) begin
            errors++;
            $display("[TB] FAIL min_play: got playing %b addr %0d note %h expected 1 0 000",
                     playing, play_addr, note_out);
        end
        cyc(1);
        checks++;
        if ({done, playing, beat_tick, note_out} !== {3'b100, 12'h001}) begin
            errors++;
            $display("[TB] FAIL min_done: got done %b playing %b tick %b note %h expected 1 0 0 001",
                     done, playing, beat_tick, note_out);
        end
        cyc(1);
        checks++;
        if (done !== 1'b0 || note_out !== 12'h000) begin
            errors++;
            $display("[TB] FAIL min_after: got done %b note %h expected 0 000", done, note_out);
        end
    endtask

    task automatic test_write_during_play();
        tempo_div = 24'd4; song_len = 7'd3; loop_en = 1'b0;
        pulse_play();
        cyc(4);
        write_word(7'd2, 12'h070);
        write_word(7'd1, 12'h300);
        checks++;
        if (note_out !== 12'h002) begin
            errors++;
            $display("[TB] FAIL read_first_old: got %h expected 002", note_out);
        end
        cyc(1);
        checks++;
        if (note_out !== 12'h300) begin
            errors++;
            $display("[TB] FAIL read_first_new: got %h expected 300", note_out);
        end
        cyc(2);
        checks++;
        if (note_out !== 12'h070 || play_addr !== 7'd2) begin
            errors++;
            $display("[TB] FAIL write_play: got note %h addr %0d expected 070 2", note_out, play_addr);
        end
        pulse_stop();
        cyc(1);
    endtask

    task automatic test_tempo_lower();
        tempo_div = 24'd8; song_len = 7'd3; loop_en = 1'b0;
        pulse_play();
        cyc(5);
        tempo_div = 24'd3;
        cyc(1);
        checks++;
        if (play_addr !== 7'd1 || beat_tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL tempo_lower: got addr %0d tick %b expected 1 1", play_addr, beat_tick);
        end
        pulse_stop();
        cyc(2);
    endtask

    task automatic test_random();
        logic [22:0] act, exp;
        int r;
        for (int s = 0; s < 8; s++) begin
            tempo_div = 24'($urandom_range(0, 5));
            song_len  = 7'($urandom_range(0, 9));
            loop_en   = 1'($urandom_range(0, 1));
            pulse_play();
            for (int c = 0; c < 120; c++) begin
                act = {note_out, play_addr, playing, paused, beat_tick, done};
                exp = {m_note, 7'(exp_addr()), m_mode == 1, m_mode == 2, m_tick, m_done};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("[TB] FAIL random s=%0d c=%0d: got %h expected %h", s, c, act, exp);
                end
                r = int'($urandom_range(0, 99));
                cmd_stop  = (r < 2);
                cmd_pause = (r >= 2 && r < 8);
                cmd_play  = (r >= 8 && r < 16);
                wr_en     = ($urandom_range(0, 9) == 0);
                wr_addr   = 7'($urandom_range(0, 15));
                wr_data   = rand_word();
                cyc(1);
            end
            cmd_play = 1'b0; cmd_pause = 1'b0; wr_en = 1'b0;
            pulse_stop();
            cyc(1);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_play = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0; loop_en = 1'b0;
        tempo_div = 24'd4; song_len = 7'd0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        load_score();
        test_play_once();
        test_loop();
        test_pause_resume();
        test_stop_priority();
        test_reset_mid_song();
        test_min_tempo();
        test_write_during_play();
        test_tempo_lower();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/music_score_player.md
Name: music_score_player

Overview:
- Parametrised successor to the fixed score ROM: a writable score RAM plus a playback sequencer.
- The RAM holds one 12-bit word per beat: {high[3:0], med[3:0], low[3:0]}, where each nibble is 0 = rest and 1-7 = scale degree. Host logic loads the RAM through a write port.
- The sequencer steps through addresses at a runtime-programmable tempo, with play, pause, stop and loop control.
- note_out feeds the existing buzzer tone generator.

Parameters:
- ROM_WIDTH, 12, width of a score word ({high, med, low} nibbles).
- ADDR_WIDTH, 7, score address width.
- ROM_DEPTH, 128, number of score words; must equal 2**ADDR_WIDTH.
- TEMPO_WIDTH, 24, width of the cycles-per-beat divider.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_play  in  1  single-cycle request: start from IDLE, or resume from PAUSE.
- cmd_pause  in  1  single-cycle request to pause playback.
- cmd_stop  in  1  single-cycle request to stop playback.
- loop_en  in  1  1 = wrap to address 0 after the last beat; 0 = stop after the last beat.
- tempo_div  in  TEMPO_WIDTH  clock cycles per beat; a value of 0 is treated as 1.
- song_len  in  ADDR_WIDTH  last address played (inclusive).
- wr_en  in  1  score RAM write strobe.
- wr_addr  in  ADDR_WIDTH  score RAM write address.
- wr_data  in  ROM_WIDTH  score RAM write data.
- note_out  out  ROM_WIDTH  current note word; 0 when not playing.
- play_addr  out  ADDR_WIDTH  address currently being played.
- playing  out  1  high while in PLAY.
- paused  out  1  high while in PAUSE.
- beat_tick  out  1  one-cycle pulse on each address advance.
- done  out  1  one-cycle pulse when a non-looping song ends.

Behaviour:
- Reset values: state=IDLE, note_out=0, play_addr=0, beat counter=0, playing=0, paused=0, beat_tick=0, done=0, len_q=0. RAM contents are not affected by reset.
- States:
  - IDLE: silent.
  - PLAY: advancing through the score.
  - PAUSE: frozen, silent.
- Command priority within a cycle is stop > pause > play.
- cmd_stop in PLAY or PAUSE: next state IDLE, play_addr←0, counter←0, no done pulse.
- cmd_pause in PLAY: next state PAUSE. play_addr and counter are held. cmd_pause is ignored in IDLE and PAUSE.
- cmd_play in IDLE: next state PLAY, play_addr←0, counter←0, len_q←song_len.
- cmd_play in PAUSE: next state PLAY, resuming with counter and play_addr unchanged.
- cmd_play in PLAY is ignored.
- song_len is captured into len_q only at start from IDLE. Later changes take effect at the next start.
- tempo_div is live and is compared every cycle. Let eff_div = max(tempo_div, 1).
- In PLAY, the counter increments each cycle. When counter == eff_div-1:
  - counter←0 and beat_tick=1 in the next cycle.
  - If play_addr != len_q: play_addr←play_addr+1.
  - If play_addr == len_q and loop_en=1: play_addr←0 (wrap; beat_tick still pulses).
  - If play_addr == len_q and loop_en=0: next state IDLE, play_addr←0, done=1 for one cycle, beat_tick=0.
- If tempo_div is lowered below counter+1 mid-beat, the comparison uses >=, so the beat ends on the next cycle.
- Each address is held for exactly eff_div cycles of PLAY. PAUSE cycles do not count.
- Read path:
  - RAM read is synchronous. note_out ← RAM[play_addr] registered when the current state is PLAY, else 0.
  - note_out therefore lags play_addr by one cycle.
  - On exit from PLAY, note_out is 0 from the following cycle.
- Write path:
  - Writes are accepted in every state.
  - A write and a read to the same address in the same cycle return the old data (read-first).
- A command arriving in the same cycle as a beat-end takes priority over the advance:
  - stop → IDLE, no done pulse.
  - pause → PAUSE, with play_addr advanced and counter←0.
- song_len=0 plays a single address. With loop_en=1 it repeats address 0 indefinitely.
- playing is high exactly when state==PLAY; paused is high exactly when state==PAUSE; both are registered.
- rst asserted mid-operation returns every output to its reset value in the next cycle. RAM contents are retained.

Test Plan:
- Load RAM[0..3] = 0x001, 0x002, 0x000, 0x005; set tempo_div=4, song_len=3, loop_en=0; pulse cmd_play → play_addr holds 0, 1, 2, 3 for 4 cycles each. note_out shows 0x001, 0x002, 0x000, 0x005 one cycle behind play_addr. beat_tick pulses 3 times, done pulses once after 16 PLAY cycles, then playing=0 and note_out=0.
- Same setup with loop_en=1 → after address 3, play_addr wraps to 0 with a beat_tick and no done pulse; 0x001 reappears on note_out.
- Pulse cmd_pause at PLAY cycle 6, wait 10 cycles, pulse cmd_play → paused=1 and note_out=0 during the pause. Address 1 completes its remaining 2 cycles after resume, and total PLAY cycles to done are still 16.
- Assert cmd_stop and cmd_play in the same cycle in PLAY → IDLE, play_addr=0, no done pulse. Assert rst mid-song → all outputs at reset values next cycle, and RAM[1] still reads 0x002 on replay.
- tempo_div=0, song_len=0, loop_en=0 → one PLAY cycle, then done; note_out pulses RAM[0] for one cycle.
- Write RAM[2]=0x070 while play_addr=1 → the value is played when address 2 is reached. Write RAM[1]=0x300 on a read of address 1 → old value 0x002 is output that cycle and 0x300 the following cycle.
